// File: rtl/multi_ch_cache.sv
// multi_ch_cache: per-channel sample FIFOs, IN_W-bit words in, OUT_W-bit lanes out
// (most-significant lane first), with a sticky overflow flag, a saturating drop
// counter and a lane-granular fill count per channel.
// Optional ramp generator for link bring-up: define MULTI_CH_CACHE_SIM_GEN_EN.

module multi_ch_cache_chan #(
   parameter int IN_W         = 16,
   parameter int OUT_W        = 8,
   parameter int DEPTH_W      = 11,
   parameter int PROG_FULL_TH = 1800
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sim_sel_i,
   input  logic             sim_trig_i,
   input  logic             wr_en_i,
   input  logic [IN_W-1:0]  wr_data_i,
   input  logic             rd_en_i,
   input  logic             ovf_clr_i,
   output logic [OUT_W-1:0] rd_data_o,
   output logic             empty_o,
   output logic             prog_full_o,
   output logic             ovf_o,
   output logic [15:0]      drop_cnt_o,
   output logic [15:0]      rd_data_count_o
);
   localparam int RATIO = IN_W / OUT_W;
   localparam int LPW   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int DEPTH = 1 << DEPTH_W;
   localparam logic [DEPTH_W:0] DEPTH_C = (DEPTH_W+1)'(DEPTH);
   localparam logic [DEPTH_W:0] PF_C    = (DEPTH_W+1)'(PROG_FULL_TH);
   localparam logic [LPW-1:0]   LAST_C  = LPW'(RATIO - 1);

   logic            src_wr;
   logic [IN_W-1:0] src_data;
   logic            wr_q;
   logic [IN_W-1:0] data_q;

`ifdef MULTI_CH_CACHE_SIM_GEN_EN
   logic [IN_W-1:0] ramp_q;

   assign src_wr   = sim_sel_i ? sim_trig_i : wr_en_i;
   assign src_data = sim_sel_i ? {RATIO{ramp_q[OUT_W-1:0]}} : wr_data_i;

   // Ramp advances once per generated write and freezes while the ramp is deselected
   always_ff @(posedge clk_i) begin
      if (rst_i)                 ramp_q <= '0;
      else if (sim_sel_i && wr_q) ramp_q <= ramp_q + 1'b1;
   end
`else
   logic unused_sim;
   assign unused_sim = sim_sel_i ^ sim_trig_i;
   assign src_wr     = wr_en_i;
   assign src_data   = wr_data_i;
`endif

   // Input stage: register the selected strobe and sample
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q   <= 1'b0;
         data_q <= '0;
      end else begin
         wr_q   <= src_wr;
         data_q <= src_data;
      end
   end

   logic [IN_W-1:0]    mem [DEPTH];
   logic [DEPTH_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DEPTH_W:0]   cnt_q, cnt_d;
   logic [LPW-1:0]     lane_q, lane_d;
   logic [OUT_W-1:0]   rdat_q, rdat_d;
   logic               ovf_q, ovf_d;
   logic [15:0]        drop_q, drop_d;
   logic [IN_W-1:0]    head, head_sh;
   logic               full, empty, push, drop, rd_acc, pop;

   // Full is judged on the registered count only, so a same-cycle pop cannot rescue a write
   assign full    = (cnt_q == DEPTH_C);
   assign empty   = (cnt_q == '0);
   assign push    = wr_q && !full;
   assign drop    = wr_q && full;
   assign rd_acc  = rd_en_i && !empty;
   assign pop     = rd_acc && (lane_q == LAST_C);
   assign head    = mem[rptr_q];
   assign head_sh = head >> (OUT_W * (RATIO - 1 - int'(lane_q)));

   // Next-state: pointers, word count, lane walk, read lane, overflow bookkeeping
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      lane_d = lane_q;
      rdat_d = rdat_q;
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (rd_acc) begin
         rdat_d = head_sh[OUT_W-1:0];
         if (pop) begin
            rptr_d = rptr_q + 1'b1;
            lane_d = '0;
         end else begin
            lane_d = lane_q + 1'b1;
         end
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      // A clear in the same cycle as a drop wins, and that drop is not counted
      if (ovf_clr_i) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         lane_q <= '0;
         rdat_q <= '0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         lane_q <= lane_d;
         rdat_q <= rdat_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
      end
   end

   // Storage write port; contents are left stale on reset and masked by the pointers
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr_q] <= data_q;
   end

   assign rd_data_o       = rdat_q;
   assign empty_o         = empty;
   assign prog_full_o     = (cnt_q >= PF_C);
   assign ovf_o           = ovf_q;
   assign drop_cnt_o      = drop_q;
   assign rd_data_count_o = 16'(cnt_q) * 16'(RATIO) - 16'(lane_q);
endmodule

module multi_ch_cache #(
   parameter int CH_NUM       = 25,
   parameter int IN_W         = 16,
   parameter int OUT_W        = 8,
   parameter int DEPTH_W      = 11,
   parameter int PROG_FULL_TH = 1800
) (
   input  logic                    sys_clk_i,
   input  logic                    rst_i,
   input  logic [CH_NUM-1:0]       wr_en_i,
   input  logic [CH_NUM*IN_W-1:0]  wr_data_i,
   input  logic                    sim_data_en_i,
   input  logic                    sim_trig_i,
   input  logic [CH_NUM-1:0]       rd_en_i,
   output logic [CH_NUM*OUT_W-1:0] rd_data_o,
   output logic [CH_NUM-1:0]       empty_o,
   output logic [CH_NUM-1:0]       prog_full_o,
   output logic [CH_NUM-1:0]       ovf_o,
   input  logic [CH_NUM-1:0]       ovf_clr_i,
   output logic [CH_NUM*16-1:0]    drop_cnt_o,
   output logic [CH_NUM*16-1:0]    rd_data_count_o
);
   logic sim_sel;

`ifdef MULTI_CH_CACHE_SIM_GEN_EN
   logic [1:0] sim_sync_q;

   // Two-flop synchroniser for the asynchronous ramp-select level
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) sim_sync_q <= '0;
      else       sim_sync_q <= {sim_sync_q[0], sim_data_en_i};
   end
   assign sim_sel = sim_sync_q[1];
`else
   logic unused_sim_en;
   assign unused_sim_en = sim_data_en_i;
   assign sim_sel       = 1'b0;
`endif

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      multi_ch_cache_chan #(
         .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH_W(DEPTH_W), .PROG_FULL_TH(PROG_FULL_TH)
      ) u_ch (
         .clk_i          (sys_clk_i),
         .rst_i          (rst_i),
         .sim_sel_i      (sim_sel),
         .sim_trig_i     (sim_trig_i),
         .wr_en_i        (wr_en_i[g]),
         .wr_data_i      (wr_data_i[g*IN_W +: IN_W]),
         .rd_en_i        (rd_en_i[g]),
         .ovf_clr_i      (ovf_clr_i[g]),
         .rd_data_o      (rd_data_o[g*OUT_W +: OUT_W]),
         .empty_o        (empty_o[g]),
         .prog_full_o    (prog_full_o[g]),
         .ovf_o          (ovf_o[g]),
         .drop_cnt_o     (drop_cnt_o[g*16 +: 16]),
         .rd_data_count_o(rd_data_count_o[g*16 +: 16])
      );
   end
endmodule

// File: tb/tb_multi_ch_cache.sv
// Directed bench for multi_ch_cache with a per-channel lane scoreboard.
module tb_multi_ch_cache;
   localparam int CH = 25;
   localparam int DEPTH = 2048;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [CH-1:0]   wr_en = '0, rd_en = '0, ovf_clr = '0;
   logic [CH*16-1:0] wr_data = '0;
   logic            sim_en = 1'b0, sim_trig = 1'b0;
   logic [CH*8-1:0] rd_data;
   logic [CH-1:0]   empty, pfull, ovf;
   logic [CH*16-1:0] drop_cnt, rd_cnt;

   int passed = 0;
   int total  = 0;
   logic [7:0] sbq [CH][$];

   multi_ch_cache dut (
      .sys_clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
      .sim_data_en_i(sim_en), .sim_trig_i(sim_trig), .rd_en_i(rd_en),
      .rd_data_o(rd_data), .empty_o(empty), .prog_full_o(pfull), .ovf_o(ovf),
      .ovf_clr_i(ovf_clr), .drop_cnt_o(drop_cnt), .rd_data_count_o(rd_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] cnt_of(input int ch);
      return rd_cnt[ch*16 +: 16];
   endfunction

   // Drive one write for one cycle; scoreboard keeps only what the FIFO should accept
   task automatic wr(input int ch, input logic [15:0] d);
      wr_en[ch] = 1'b1;
      wr_data[ch*16 +: 16] = d;
      if ((sbq[ch].size() + 1) / 2 < DEPTH) begin
         sbq[ch].push_back(d[15:8]);
         sbq[ch].push_back(d[7:0]);
      end
      tick();
      wr_en[ch] = 1'b0;
   endtask

   task automatic rd(input int ch, input string tag);
      logic [7:0] e;
      rd_en[ch] = 1'b1;
      tick();
      rd_en[ch] = 1'b0;
      e = sbq[ch].pop_front();
      chk(tag, 32'(rd_data[ch*8 +: 8]), 32'(e));
   endtask

   initial begin
      logic [7:0] e;
      tick(); tick();
      rst = 1'b0;
      tick();
      // Reset / idle
      chk("rst_empty", 32'(empty), 32'h1FF_FFFF);
      chk("rst_cnt0", 32'(cnt_of(0)), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_drop3", 32'(drop_cnt[3*16 +: 16]), 0);
      chk("rst_pfull", 32'(pfull), 0);

      // Ch0: two words, four lanes MS first
      wr(0, 16'hA55A);
      wr(0, 16'h1234);
      tick();
      chk("ch0_cnt4", 32'(cnt_of(0)), 4);
      chk("ch0_nempty", 32'(empty[0]), 0);
      for (int i = 0; i < 4; i++) begin
         rd(0, "ch0_data");
         chk("ch0_cnt", 32'(cnt_of(0)), 32'(3 - i));
      end
      chk("ch0_empty", 32'(empty[0]), 1);
      rd_en[0] = 1'b1; tick(); rd_en[0] = 1'b0;
      chk("ch0_rd_empty_hold", 32'(rd_data[7:0]), 32'h34);
      chk("ch0_rd_empty_cnt", 32'(cnt_of(0)), 0);

      // Ch3: overfill, prog_full threshold, drops, clear
      for (int j = 0; j < DEPTH + 5; j++) begin
         wr(3, 16'(j * 7 + 3));
         if (j == 1799) chk("ch3_pf_below", 32'(pfull[3]), 0);
         if (j == 1800) chk("ch3_pf_at", 32'(pfull[3]), 1);
         if (j == 2048) chk("ch3_no_ovf_yet", 32'(ovf[3]), 0);
      end
      tick(); tick();
      chk("ch3_cnt_full", 32'(cnt_of(3)), 4096);
      chk("ch3_ovf", 32'(ovf[3]), 1);
      chk("ch3_drop5", 32'(drop_cnt[3*16 +: 16]), 5);
      chk("ch3_other_ovf", 32'(ovf & ~(25'(1) << 3)), 0);
      ovf_clr[3] = 1'b1; tick(); ovf_clr[3] = 1'b0;
      chk("ch3_ovf_clr", 32'(ovf[3]), 0);
      chk("ch3_drop_clr", 32'(drop_cnt[3*16 +: 16]), 0);
      chk("ch3_cnt_kept", 32'(cnt_of(3)), 4096);
      for (int i = 0; i < 4; i++) rd(3, "ch3_data");
      chk("ch3_cnt_after_rd", 32'(cnt_of(3)), 4092);

      // Ch1: fill 10 words, then read+write every cycle
      for (int j = 0; j < 10; j++) wr(1, 16'h1100 + 16'(j));
      tick();
      chk("ch1_fill", 32'(cnt_of(1)), 20);
      for (int k = 0; k < 100; k++) begin
         logic [15:0] d;
         d = 16'h3000 + 16'(k * 3);
         wr_en[1] = 1'b1; rd_en[1] = 1'b1;
         wr_data[16 +: 16] = d;
         sbq[1].push_back(d[15:8]);
         sbq[1].push_back(d[7:0]);
         tick();
         e = sbq[1].pop_front();
         chk("ch1_rw_data", 32'(rd_data[8 +: 8]), 32'(e));
         chk("ch1_rw_cnt", 32'(cnt_of(1)), 32'(19 + k));
      end
      wr_en[1] = 1'b0; rd_en[1] = 1'b0;
      tick();
      chk("ch1_final_cnt", 32'(cnt_of(1)), 120);
      chk("ch1_no_ovf", 32'(ovf[1]), 0);

      // Ch2: reset in the middle of a burst
      for (int j = 0; j < 3; j++) wr(2, 16'hC000 + 16'(j));
      wr_en[2] = 1'b1; wr_data[32 +: 16] = 16'hC003; rd_en[2] = 1'b1;
      tick();
      rd_en[2] = 1'b0;
      chk("ch2_pre_rst_rd", 32'(rd_data[16 +: 8]), 32'hC0);
      rst = 1'b1;
      tick();
      wr_en[2] = 1'b0;
      chk("mrst_empty", 32'(empty), 32'h1FF_FFFF);
      chk("mrst_rdata", 32'(rd_data[16 +: 8]), 0);
      chk("mrst_cnt_any", 32'(|rd_cnt), 0);
      chk("mrst_pfull", 32'(pfull), 0);
      chk("mrst_ovf", 32'(ovf), 0);
      rst = 1'b0;
      for (int c = 0; c < CH; c++) sbq[c].delete();
      tick(); tick();
      chk("ch2_pending_dropped", 32'(cnt_of(2)), 0);
      wr(2, 16'hBEEF);
      tick();
      chk("ch2_restart_cnt", 32'(cnt_of(2)), 2);
      rd(2, "ch2_restart_data");
      rd(2, "ch2_restart_data");

      // Ramp generator
      sim_en = 1'b1;
      tick(); tick(); tick();
      for (int p = 0; p < 3; p++) begin
         sim_trig = 1'b1; tick(); sim_trig = 1'b0; tick(); tick();
`ifdef MULTI_CH_CACHE_SIM_GEN_EN
         for (int c = 0; c < CH; c++) begin
            sbq[c].push_back(8'(p));
            sbq[c].push_back(8'(p));
         end
`endif
      end
      sim_en = 1'b0;
      tick(); tick(); tick();
`ifdef MULTI_CH_CACHE_SIM_GEN_EN
      chk("sim_cnt_ch0", 32'(cnt_of(0)), 6);
      chk("sim_cnt_ch24", 32'(cnt_of(24)), 6);
      chk("sim_empty", 32'(empty), 0);
      for (int i = 0; i < 6; i++) rd(0, "sim_data_ch0");
      for (int i = 0; i < 6; i++) rd(24, "sim_data_ch24");
`else
      chk("sim_off_empty", 32'(empty), 32'h1FF_FFFF);
      chk("sim_off_cnt", 32'(|rd_cnt), 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/multi_ch_cache.md
# multi_ch_cache

Parametrised per-channel sensor sample cache between the ADC acquisition front end and the packet/readout logic. Each of CH_NUM channels owns an independent FIFO that accepts IN_W-bit samples and delivers OUT_W-bit lanes, with an optional built-in ramp generator for link bring-up. Beyond a plain 16-to-8 cache, it adds generic width ratio and depth, a sticky per-channel overflow flag with clear, a saturating drop counter, and an exact lane-granular fill count.

## Interface
Parameters:
- CH_NUM, 25, number of channels
- IN_W, 16, write sample width; must equal RATIO*OUT_W with integer RATIO ≥ 1
- OUT_W, 8, read lane width
- DEPTH_W, 11, log2 of FIFO depth in IN_W words (DEPTH = 2^DEPTH_W)
- PROG_FULL_TH, 1800, word count at or above which prog_full_o asserts

Ports (one clock; reset is synchronous and active-high):
- sys_clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- wr_en_i  in  CH_NUM  per-channel sample strobe
- wr_data_i  in  CH_NUM*IN_W  samples, channel i at [i*IN_W +: IN_W]
- sim_data_en_i  in  1  select internal ramp instead of wr_data_i; asynchronous level
- sim_trig_i  in  1  ramp write strobe, common to all channels
- rd_en_i  in  CH_NUM  per-channel lane read request
- rd_data_o  out  CH_NUM*OUT_W  read lanes, channel i at [i*OUT_W +: OUT_W]
- empty_o  out  CH_NUM  no unread lane in channel
- prog_full_o  out  CH_NUM  word count ≥ PROG_FULL_TH
- ovf_o  out  CH_NUM  sticky: a write was dropped
- ovf_clr_i  in  CH_NUM  clears ovf_o and drop count of channel
- drop_cnt_o  out  CH_NUM*16  saturating dropped-write count per channel
- rd_data_count_o  out  CH_NUM*16  unread lanes per channel, zero-extended

## Operation
- sim_data_en_i is double-flopped (sim_sel); source switch takes effect 2 edges after the level change.
- Input stage, per channel, registered: wr_q = sim_sel ? sim_trig_i : wr_en_i[i]; data_q = sim_sel ? {RATIO{ramp[OUT_W-1:0]}} : wr_data_i[i].
- Ramp: per-channel IN_W counter, increments on each cycle where sim_sel and wr_q are high; wraps modulo 2^IN_W; holds its value while sim_sel is low.
- Write stage: if wr_q and word count < DEPTH, store data_q; otherwise drop, set ovf_o, and increment drop_cnt_o, saturating at 0xFFFF. Full is judged on the registered count only; a read that frees a word in the same cycle does not save the write.
- Read: lanes are delivered most-significant lane first. A lane pointer 0..RATIO-1 walks the head word, and the word is popped when the last lane is read. rd_en_i while empty_o is ignored, and no state changes.
- rd_data_count_o = words*RATIO − lane_ptr. Requires DEPTH_W + log2(RATIO) + 1 ≤ 16.
- If ovf_clr_i and a drop occur in the same cycle, clear wins for ovf_o and drop_cnt_o; that drop is not counted.
- Storage: one inferred simple dual-port RAM per channel, with DEPTH_W-bit pointers and a (DEPTH_W+1)-bit word count. Pointers wrap naturally.
- Reset values: pointers, counts, lane_ptr, ramp, sim_sel, drop_cnt_o and ovf_o are 0. empty_o is all-1, prog_full_o is 0, rd_data_o is 0, rd_data_count_o is 0. Reset mid-operation discards all contents.

## Timing
- wr_en_i high in cycle N: wr_q is set at edge N+1, the RAM write happens at edge N+2, and empty_o, rd_data_count_o and prog_full_o reflect it after edge N+2.
- rd_en_i accepted in cycle M: rd_data_o is valid after edge M+1 and held until the next accepted read. Counts and empty_o update after edge M+1.
- Back-to-back reads every cycle are supported at full rate. Simultaneous read and write in one channel is supported; the count changes by +RATIO−1 when a read and a write land in the same cycle.
- ovf_o sets after the edge of the dropped write.

## Configuration
- MULTI_CH_CACHE_SIM_GEN_EN defined: the synchroniser, ramp counters and source mux are built as described above.
- MULTI_CH_CACHE_SIM_GEN_EN undefined: none of the ramp logic is built. sim_data_en_i and sim_trig_i are ignored, and wr_q/data_q always come from wr_en_i/wr_data_i. Latency is unchanged.

## Test plan
- Reset, then idle: empty_o all-1, rd_data_count_o 0, ovf_o 0, drop_cnt_o 0.
- Ch0 writes 0xA55A and 0x1234, then reads 4 lanes: rd_data_o[7:0] gives 0xA5, 0x5A, 0x12, 0x34. Count steps 4→3→2→1→0, and empty_o[0] rises after the last read.
- Ch3 writes DEPTH+5 words with no reads: word 2048 is accepted, 5 writes are dropped, ovf_o[3]=1, drop_cnt_o[3]=5, and prog_full_o[3] asserts at the 1800th word. Then pulse ovf_clr_i[3]: both clear, and the stored data is intact.
- sim_data_en_i=1 with 3 sim_trig_i pulses: every channel stores 0x0000, 0x0101, 0x0202. With the macro undefined, the same stimulus stores nothing.
- Fill ch1 with 10 words, then read and write every cycle for 100 cycles: no drops, data order preserved, and the count rises by 1 per cycle (RATIO=2).
- Assert rst_i mid-burst on ch2: all outputs return to their reset values on the next edge, and subsequent writes restart from an empty FIFO.
